// File: rtl/mem_req_pkg.sv
// Shared definitions for the mem_requester block.
// Contents:
//   state_t     - requester FSM states (IDLE, SETUP, ACCESS, RELEASE)
//   OP_READ     - op encoding for a read  (0)
//   OP_WRITE    - op encoding for a write (1)
//   DEF_ADDR_W  - default word-address width
//   DEF_DATA_W  - default word width (matches mem_word)
package mem_req_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      ACCESS  = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/mem_requester_if.sv
// Bundle of the client request/response port and the word-memory bus.
// Parameters: ADDR_W (word address width), DATA_W (word width).
// Signals:
//   req_valid/req_ready/req_op/req_addr/req_wdata - client request handshake
//   rsp_valid/rsp_rdata/rsp_err                  - one-cycle completion
//   mem_select/mem_op/mem_addr/mem_wdata          - requester -> responder
//   mem_rdata/mem_valid                           - responder -> requester
// Modports:
//   master - the requester side (mem_requester)
//   slave  - the environment side (client + responder)
interface mem_requester_if
   import mem_req_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              req_valid;
   logic              req_ready;
   logic              req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   logic              mem_select;
   logic              mem_op;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_valid;

   modport master (
      input  req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_valid,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_select, mem_op, mem_addr, mem_wdata
   );

   modport slave (
      output req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_valid,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_select, mem_op, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_req_timer.sv
// Watchdog counter for the ACCESS phase.
// Parameter: TIMEOUT (1..255) - expire_o asserts when the count reaches TIMEOUT-1.
// Ports:
//   clk      - clock
//   reset_n  - asynchronous active-low reset
//   clear_i  - synchronous clear to 0 (has priority over enable_i)
//   enable_i - count one per cycle; the count saturates at TIMEOUT-1
//   expire_o - count == TIMEOUT-1
module mem_req_timer
   import mem_req_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   // A one-bit counter still works for TIMEOUT=1 (expiry at count 0).
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_requester.sv
// Host-side initiator for the word-memory access protocol. Accepts one client
// request at a time, presents it to the responder (SETUP then ACCESS with
// mem_select high), waits for mem_valid or a watchdog timeout, returns a
// one-cycle completion, and always leaves a one-cycle select gap (RELEASE).
// Parameters: ADDR_W, DATA_W, TIMEOUT (max ACCESS cycles, 1..255).
// Ports:
//   clk     - clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - mem_requester_if.master (client request/response + memory bus)
// Optional feature, macro MEM_REQUESTER_RETRY_EN: the first timeout silently
// re-runs SETUP/ACCESS with the same op/addr/wdata; only a second timeout is
// reported as rsp_err.
module mem_requester
   import mem_req_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 15
) (
   input logic             clk,
   input logic             reset_n,
   mem_requester_if.master bus
);

   state_t            state_q, state_d;
   logic              op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              rsp_valid_q;
   logic              rsp_err_q;
   logic [DATA_W-1:0] rdata_q;

   logic tmr_expire;
   logic access_ok;
   logic access_to;
   logic report_err;
   logic retry_pend;

   mem_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear_i  (state_q == SETUP),
      .enable_i (state_q == ACCESS),
      .expire_o (tmr_expire)
   );

   // mem_valid wins over a simultaneous expiry.
   assign access_ok = (state_q == ACCESS) && bus.mem_valid;
   assign access_to = (state_q == ACCESS) && !bus.mem_valid && tmr_expire;

`ifdef MEM_REQUESTER_RETRY_EN
   logic retry_q;

   // Set by the first timeout, cleared by whichever completion follows.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         retry_q <= 1'b0;
      end else if (access_ok || report_err) begin
         retry_q <= 1'b0;
      end else if (access_to) begin
         retry_q <= 1'b1;
      end
   end

   assign report_err = access_to && retry_q;
   // Still set in RELEASE only when the first attempt timed out.
   assign retry_pend = retry_q;
`else
   assign report_err = access_to;
   assign retry_pend = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.req_valid) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (bus.mem_valid || tmr_expire) state_d = RELEASE;
         RELEASE: state_d = retry_pend ? SETUP : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request capture; held through the transaction and retained in IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if ((state_q == IDLE) && bus.req_valid) begin
         op_q    <= bus.req_op;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
      end
   end

   // Completion: rsp_valid is a single pulse in RELEASE; rdata holds until
   // the next completion and is zero for writes and errors.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rdata_q     <= '0;
      end else begin
         rsp_valid_q <= access_ok || report_err;
         rsp_err_q   <= report_err;
         if (access_ok) begin
            rdata_q <= (op_q == OP_READ) ? bus.mem_rdata : '0;
         end else if (report_err) begin
            rdata_q <= '0;
         end
      end
   end

   // Outputs
   always_comb begin
      bus.req_ready  = (state_q == IDLE);
      bus.mem_select = (state_q == ACCESS);
      bus.mem_op     = op_q;
      bus.mem_addr   = addr_q;
      bus.mem_wdata  = wdata_q;
      bus.rsp_valid  = rsp_valid_q;
      bus.rsp_err    = rsp_err_q;
      bus.rsp_rdata  = rdata_q;
   end

endmodule
